// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (reset > redirect > stall > +4),
// IF/ID pipeline register with redirect bubbles, and saturating fetch/bubble counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,       // active-high despite the name: asserted = 1
  input  logic             stall,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc4,
  output logic             id_valid,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD,
    KILL
  } stage_e;

  stage_e      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // Redirect outranks stall: the redirecting instruction in EX is older than the
  // load-use pair being held, so the held fetch is wrong-path anyway.
  // NOTE: all state uses non-blocking assignments so every register samples the
  // pre-edge values of pc and the counters, regardless of statement order.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      id_inst    <= 32'h0;
      id_pc      <= 32'h0;
      id_pc4     <= 32'h0;
      id_valid   <= 1'b0;
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (ex_redirect) begin
      state    <= KILL;
      pc       <= {ex_target[31:2], 2'b00};
      id_inst  <= 32'h0;
      id_pc    <= 32'h0;
      id_pc4   <= 32'h0;
      id_valid <= 1'b0;
      if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
    end else if (stall) begin
      state <= (state == BOOT) ? BOOT : HOLD;
    end else begin
      state    <= RUN;
      pc       <= pc_plus4;
      id_inst  <= imem_rdata;
      id_pc    <= pc;
      id_pc4   <= pc_plus4;
      id_valid <= 1'b1;
      if (fetch_cnt != '1) fetch_cnt <= fetch_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a reference model pushes expected IF/ID contents into a
// scoreboard queue as each step is driven; they are popped and compared after the edge.
module tb_if_stage;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] valid;
    logic [31:0] addr;
    logic [31:0] fcnt;
    logic [31:0] bcnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        ex_redirect;
  logic [31:0] ex_target;

  logic [31:0] imem_addr, imem_rdata, id_inst, id_pc, id_pc4;
  logic        id_valid;
  logic [31:0] fetch_cnt, bubble_cnt;

  logic [31:0] w_addr, w_rdata, w_inst, w_pc, w_pc4;
  logic        w_valid;
  logic [31:0] w_fcnt, w_bcnt;

  int checks   = 0;
  int failures = 0;

  exp_t sb_q[$];

  logic [31:0] m_pc, m_inst, m_ipc, m_pc4, m_valid, m_fc, m_bc;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00a0_0113;
      32'h0000_0008: return 32'h0020_81b3;
      default:       return a ^ 32'h5A00_0013;
    endcase
  endfunction

  assign imem_rdata = rom(imem_addr);
  assign w_rdata    = rom(w_addr);

  if_stage #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ex_redirect(ex_redirect),
    .ex_target(ex_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4), .id_valid(id_valid),
    .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(32)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ex_redirect(ex_redirect),
    .ex_target(ex_target), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .id_inst(w_inst), .id_pc(w_pc), .id_pc4(w_pc4), .id_valid(w_valid),
    .fetch_cnt(w_fcnt), .bubble_cnt(w_bcnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_ipc = 32'h0; m_pc4 = 32'h0;
    m_valid = 32'h0; m_fc = 32'h0; m_bc = 32'h0;
    sb_q.delete();
  endtask

  // Called at a negedge: drives inputs, pushes the expected post-edge state, then
  // samples 1 time unit after the rising edge and compares.
  task automatic step(input logic s, input logic r, input logic [31:0] t);
    exp_t e;
    exp_t got;
    stall = s; ex_redirect = r; ex_target = t;
    if (r) begin
      m_inst = 32'h0; m_ipc = 32'h0; m_pc4 = 32'h0; m_valid = 32'h0;
      if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
      m_pc = {t[31:2], 2'b00};
    end else if (!s) begin
      m_inst = rom(m_pc); m_ipc = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 32'h1;
      if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
      m_pc = m_pc + 32'd4;
    end
    e.inst = m_inst; e.pc = m_ipc; e.pc4 = m_pc4; e.valid = m_valid;
    e.addr = m_pc; e.fcnt = m_fc; e.bcnt = m_bc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'h1, 32'h0);
    end else begin
      got = sb_q.pop_front();
      check("id_inst", id_inst, got.inst);
      check("id_pc", id_pc, got.pc);
      check("id_pc4", id_pc4, got.pc4);
      check("id_valid", {31'h0, id_valid}, got.valid);
      check("imem_addr", imem_addr, got.addr);
      check("fetch_cnt", fetch_cnt, got.fcnt);
      check("bubble_cnt", bubble_cnt, got.bcnt);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_inst"}, id_inst, 32'h0);
    check({tag, "_pc"}, id_pc, 32'h0);
    check({tag, "_pc4"}, id_pc4, 32'h0);
    check({tag, "_valid"}, {31'h0, id_valid}, 32'h0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_fcnt"}, fetch_cnt, 32'h0);
    check({tag, "_bcnt"}, bubble_cnt, 32'h0);
    check({tag, "_waddr"}, w_addr, 32'hFFFF_FFF8);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; stall = 1'b0; ex_redirect = 1'b0; ex_target = 32'h0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b0;

    // Sequential fetch of the first two words.
    step(1'b0, 1'b0, 32'h0);
    check("tp_inst0", id_inst, 32'h0050_0093);
    step(1'b0, 1'b0, 32'h0);
    check("tp_pc1", id_pc, 32'h4);

    // Two-cycle stall while id_pc = 4.
    step(1'b1, 1'b0, 32'h0);
    check("stall_addr", imem_addr, 32'h8);
    step(1'b1, 1'b0, 32'h0);
    check("stall_inst", id_inst, 32'h00a0_0113);
    check("stall_fcnt", fetch_cnt, 32'd2);

    // Resume at pc 8, then 12.
    step(1'b0, 1'b0, 32'h0);
    check("tp_inst2", id_inst, 32'h0020_81b3);
    check("tp_pc4_2", id_pc4, 32'd12);
    check("tp_fcnt3", fetch_cnt, 32'd3);
    step(1'b0, 1'b0, 32'h0);

    // Redirect to 0x41 while pc = 0x10.
    check("pre_redir_pc", imem_addr, 32'h10);
    step(1'b0, 1'b1, 32'h0000_0041);
    check("redir_addr", imem_addr, 32'h40);
    check("redir_bcnt", bubble_cnt, 32'd1);
    step(1'b0, 1'b0, 32'h0);
    check("redir_idpc", id_pc, 32'h40);

    // Redirect and stall together: redirect wins.
    step(1'b1, 1'b1, 32'h0000_0083);
    check("both_addr", imem_addr, 32'h80);
    check("both_valid", {31'h0, id_valid}, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("both_idpc", id_pc, 32'h80);
    step(1'b0, 1'b0, 32'h0);

    // Reset asserted mid-stall, away from the edge.
    stall = 1'b1;
    #3;
    rst_n = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    check_reset_values("midrst_hold");
    rst_n = 1'b0;
    model_reset();

    // Restart at RESET_PC; the wrap instance walks across 2^32.
    step(1'b0, 1'b0, 32'h0);
    check("restart_inst", id_inst, 32'h0050_0093);
    check("wrap_pc0", w_pc, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 32'h0);
    check("wrap_pc1", w_pc, 32'hFFFF_FFFC);
    check("wrap_pc4_1", w_pc4, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("wrap_pc2", w_pc, 32'h0);
    check("wrap_inst2", w_inst, 32'h0050_0093);
    check("wrap_fcnt", w_fcnt, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage RV32I pipeline, directly upstream of the decode stage. Holds the program counter, drives the instruction-ROM address, selects sequential or redirected next PC, and registers the fetched instruction and its PC into the IF/ID pipeline register consumed by decode. Stall holds the stage. A control-flow redirect from EX kills the wrong-path fetch by inserting a bubble. Two saturating performance counters expose fetch and bubble counts for trace and debug.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset; the first instruction fetched.
- CNT_W, 32, width of the performance counters.

- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-high reset (asserted = 1); clears all state immediately.
- stall  in  1  load-use hold from the hazard unit; freezes PC and IF/ID.
- ex_redirect  in  1  EX resolved a taken branch or a jump (jal/jalr).
- ex_target  in  32  redirect target PC from EX.
- imem_addr  out  32  instruction-ROM address; combinational, equal to pc.
- imem_rdata  in  32  instruction word; combinational ROM read of imem_addr.
- id_inst  out  32  IF/ID instruction; 32'h0 denotes a bubble (decode treats inst[6:0]==0 as no instruction).
- id_pc  out  32  PC of id_inst.
- id_pc4  out  32  id_pc + 4, for the jal/jalr link write-back.
- id_valid  out  1  id_inst is a real fetched instruction.
- fetch_cnt  out  CNT_W  instructions accepted into IF/ID.
- bubble_cnt  out  CNT_W  bubbles inserted by redirect.

## Operation
- Registers: pc, id_inst, id_pc, id_pc4, id_valid, fetch_cnt, bubble_cnt.
- Next-PC selection, evaluated each edge, in priority order:
  - reset: pc = RESET_PC.
  - ex_redirect = 1: pc = {ex_target[31:2], 2'b00}. Bits [1:0] are forced to zero.
  - stall = 1: pc is held.
  - otherwise: pc = pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- IF/ID update, using the same priority:
  - redirect: id_inst = 0, id_valid = 0, id_pc and id_pc4 = 0. Bubble. bubble_cnt increments.
  - stall: all IF/ID registers are held. No counter changes.
  - normal: id_inst = imem_rdata, id_pc = pc, id_pc4 = pc + 4, id_valid = 1. fetch_cnt increments.
- Redirect and stall asserted together: redirect wins. The redirecting instruction in EX is older than the stalled load-use pair.
- Counters saturate at all-ones and do not wrap.
- Flushing the ID/EX register on a redirect is outside this block.
- Effective stage state:
  - BOOT: after reset, IF/ID holds a bubble.
  - RUN
  - HOLD: stall asserted.
  - KILL: redirect cycle.
- State transitions:
  - BOOT to RUN on the first edge with no stall and no redirect.
  - RUN or HOLD to KILL on redirect.
  - KILL to RUN on the following edge.

## Timing
- Reset values: pc = RESET_PC; id_inst, id_pc, id_pc4 = 0; id_valid = 0; both counters = 0; imem_addr = RESET_PC.
- Reset takes effect immediately on assertion. Deassertion is synchronous to clk by external convention.
- Reset mid-stream discards IF/ID contents with no further counter updates.
- Fetch latency: one cycle. The instruction at PC p, fetched in cycle n, appears on id_inst in cycle n+1.
- Redirect: ex_redirect sampled at edge n. id_inst is a bubble in cycle n+1, and imem_addr = target in cycle n+1. The target instruction reaches ID in cycle n+2. Taken-branch penalty is two cycles; this block supplies one bubble.
- Stall for k cycles freezes imem_addr and all IF/ID outputs for exactly k cycles.
- No combinational path from stall or ex_redirect to any output except through registers. imem_addr depends only on pc.

## Test plan
- Reset then run with RESET_PC=0 and ROM words 0x00500093, 0x00a00113, 0x002081b3: id_inst shows those three words on cycles 1, 2, 3. id_pc = 0, 4, 8. id_pc4 = 4, 8, 12. fetch_cnt = 3.
- Stall held for 2 cycles while id_pc = 4: imem_addr stays 8 and id_inst stays 0x00a00113 for both cycles. Counters do not change. Normal fetch resumes at pc 8.
- Redirect to ex_target 0x0000_0041 while pc = 0x10: the next cycle shows id_inst = 0, id_valid = 0, bubble_cnt +1, imem_addr = 0x40. The cycle after shows id_pc = 0x40.
- Redirect and stall both asserted in the same cycle: redirect behaviour is observed exactly as in the previous case. The PC is not held.
- Preload pc near 0xFFFF_FFF8 via RESET_PC = 0xFFFF_FFF8: id_pc sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. id_pc4 of 0xFFFF_FFFC is 0.
- Assert rst_n mid-stall, off the clock edge: all outputs return to their reset values immediately. After release, fetch restarts at RESET_PC.
